seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, registered successor to the team's 8-bit combinational ALU. It is WIDTH bits wide and keeps the existing aluMode encodings. It adds XOR, iterative shifts and an iterative shift-add multiply, plus status flags and a valid/ready handshake on both sides. It sits between the register-file read stage and write-back, and its result is held until the consumer accepts it.

## Interface
- WIDTH, 8: operand/result width; power of two, ≥4. SH = log2(WIDTH).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; shift amount is b[SH-1:0].
- aluMode  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result (low half for MUL).
- s_hi  out  WIDTH  MUL high half; 0 for all other ops.
- flag_z, flag_n, flag_c, flag_v  out  1 each  zero, negative, carry, signed overflow.
- err  out  1  illegal opcode.

## Operation
- Opcodes:
  - 0001 NOT a
  - 0011 ADD a+b
  - 0100 SUB a−b (a+~b+1)
  - 0101 AND
  - 0110 OR
  - 0111 XOR
  - 1000 SHL a by b[SH-1:0], logical
  - 1001 SHR a by b[SH-1:0], logical
  - 1010 CLEAR (s=0)
  - 1011 MUL unsigned a×b → {s_hi,s}
  - Any other code: s=0, s_hi=0, err=1, all other flags 0.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept when in_valid=1. Capture a, b and aluMode; later input changes are ignored.
  - Single-cycle ops (NOT/ADD/SUB/AND/OR/XOR/CLEAR/illegal): IDLE→DONE.
  - SHL/SHR with amount 0: IDLE→DONE; s=a, C=0.
  - SHL/SHR with amount k>0: IDLE→BUSY, shift one bit per cycle for k cycles, then →DONE.
  - MUL: IDLE→BUSY for exactly WIDTH shift-add iterations (2·WIDTH-bit accumulator), then →DONE.
  - DONE: out_valid=1; s, s_hi and flags stable. On out_ready=1 →IDLE. No new op is accepted in that same cycle.
  - in_ready=0 in BUSY and DONE. in_valid is ignored there.
- Flags are computed on the final result:
  - Z = (s==0).
  - N = s[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = carry out of a+~b+1 (1 ⇔ a≥b unsigned); V = signed overflow.
  - SHL/SHR: C = last bit shifted out; V=0.
  - MUL: C = (s_hi≠0); V=0; Z and N reflect s only.
  - Logic/NOT/CLEAR: C=V=0.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst=1 at a clock edge):
  - State→IDLE.
  - out_valid=0; s, s_hi, all flags and err =0.
  - in_ready=0 while rst is high, 1 from the first cycle after release.
- Reset mid-BUSY or mid-DONE aborts the op. The result is discarded and out_valid is never raised for it.
- Latency is measured from the accept edge t to the first cycle with out_valid=1:
  - single-cycle ops: t+1
  - shift by k: t+1+k
  - MUL: t+1+WIDTH
- Throughput: at most one op per 2 cycles (accept, DONE with out_ready=1). Back-pressure extends DONE indefinitely.
- in_ready and out_valid are registered-state decodes. No combinational path from in_valid or out_ready to in_ready.

## Test plan
- Reset, then ADD a=0xFF b=0x01, out_ready=1 → at t+1: s=0x00, Z=1, C=1, V=0, N=0, out_valid high 1 cycle; in_ready=1 at t+2.
- SUB a=0x80 b=0x01 → s=0x7F, V=1, C=1, N=0. SUB a=0x01 b=0x02 → s=0xFF, C=0, N=1.
- MUL a=0xFF b=0xFF → s=0x01, s_hi=0xFE, C=1, out_valid first at t+9. MUL 0x0F×0x11 → s=0xFF, s_hi=0x00, C=0.
- SHR a=0x81 b=3 → s=0x10, C=0 at t+4. SHL a=0x81 b=1 → s=0x02, C=1 at t+2. SHL b=0 → s=a at t+1.
- Back-pressure: ADD 0x05+0x03, out_ready=0 for 5 cycles while in_valid=1 with new operands → s=0x08 held stable, in_ready=0, second op not accepted until the cycle after out_ready=1.
- Illegal aluMode=0010 → s=0, err=1. rst asserted on cycle 4 of a MUL → next cycle out_valid=0, s=0; no result ever emitted for the aborted op.

Source files
------------

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with a valid/ready handshake on each side.
// Shifts run one bit per cycle. MUL is an iterative shift-add.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluMode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err
);

  localparam int SH = $clog2(WIDTH);
  localparam int CW = SH + 1;

  localparam logic [3:0] OP_NOT = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_CLR = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic               isMul_q, isMul_d;
  logic               shl_q, shl_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [WIDTH-1:0]   shi_q, shi_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d, err_q, err_d;

  logic [WIDTH:0]     addRes, subRes, mulSum;
  logic [WIDTH-1:0]   res;
  logic [2*WIDTH-1:0] accNext;
  logic [SH-1:0]      shAmt;
  logic               cOut, vOut, illegal;

  assign addRes = {1'b0, a} + {1'b0, b};
  assign subRes = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shAmt  = b[SH-1:0];

  always_comb begin
    state_d = state_q;
    isMul_d = isMul_q;
    shl_d   = shl_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    shi_d   = shi_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    res     = '0;
    cOut    = 1'b0;
    vOut    = 1'b0;
    illegal = 1'b0;
    mulSum  = '0;
    accNext = acc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DONE;
          case (aluMode)
            OP_NOT: res = ~a;
            OP_ADD: begin
              res  = addRes[WIDTH-1:0];
              cOut = addRes[WIDTH];
              vOut = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              res  = subRes[WIDTH-1:0];
              cOut = subRes[WIDTH];
              vOut = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_CLR: res = '0;
            OP_SHL, OP_SHR: begin
              res = a;
              // A zero shift amount finishes immediately with s=a and C=0.
              if (shAmt != '0) begin
                state_d = BUSY;
                acc_d   = {{WIDTH{1'b0}}, a};
                cnt_d   = {1'b0, shAmt};
                shl_d   = (aluMode == OP_SHL);
                isMul_d = 1'b0;
              end
            end
            OP_MUL: begin
              state_d = BUSY;
              acc_d   = {{WIDTH{1'b0}}, b};
              mcand_d = a;
              cnt_d   = CW'(WIDTH);
              isMul_d = 1'b1;
            end
            default: illegal = 1'b1;
          endcase
          if (state_d == DONE) begin
            s_d   = res;
            shi_d = '0;
            z_d   = !illegal && (res == '0);
            n_d   = res[WIDTH-1];
            c_d   = cOut;
            v_d   = vOut;
            err_d = illegal;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        // Multiply step: conditionally add the multiplicand to the upper half, then shift right.
        if (isMul_q) begin
          mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
          accNext = {mulSum, acc_q[WIDTH-1:1]};
        end else if (shl_q) begin
          accNext = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], 1'b0};
          cOut    = acc_q[WIDTH-1];
        end else begin
          accNext = {{WIDTH{1'b0}}, 1'b0, acc_q[WIDTH-1:1]};
          cOut    = acc_q[0];
        end
        acc_d = accNext;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          s_d     = accNext[WIDTH-1:0];
          shi_d   = isMul_q ? accNext[2*WIDTH-1:WIDTH] : '0;
          z_d     = (accNext[WIDTH-1:0] == '0);
          n_d     = accNext[WIDTH-1];
          c_d     = isMul_q ? (accNext[2*WIDTH-1:WIDTH] != '0) : cOut;
          v_d     = 1'b0;
          err_d   = 1'b0;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      isMul_q <= 1'b0;
      shl_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      shi_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      isMul_q <= isMul_d;
      shl_q   <= shl_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      shi_q   <= shi_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign s_hi      = shi_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8).
// It covers latency, flags, back-pressure, illegal opcodes and reset abort.
module tb_seq_alu;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       aluMode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_hi;
  logic             flag_z, flag_n, flag_c, flag_v, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluMode(aluMode), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .s_hi(s_hi), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .flag_v(flag_v), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one op, takes the accept edge, then scrambles the inputs so that capture is exercised.
  task automatic applyStimulus(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [3:0] mode);
    a = ia; b = ib; aluMode = mode; in_valid = 1'b1;
    check({tag, "_inReady"}, 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    a = ~ia; b = ~ib; aluMode = 4'b1010;
    check({tag, "_busyNotReady"}, 16'(in_ready), 16'h0);
  endtask

  // Flags are packed as {z,n,c,v,err}.
  task automatic checkOutput(input string tag, input int expLat, input logic [7:0] expS,
                             input logic [7:0] expHi, input logic [4:0] expFlags);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(expLat));
    check({tag, "_s"}, 16'(s), 16'(expS));
    check({tag, "_sHi"}, 16'(s_hi), 16'(expHi));
    check({tag, "_flags"}, 16'({flag_z, flag_n, flag_c, flag_v, err}), 16'(expFlags));
    tick();
    check({tag, "_validDrop"}, 16'(out_valid), 16'h0);
    check({tag, "_readyBack"}, 16'(in_ready), 16'h1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; aluMode = '0;
    tick();
    tick();
    check("rst_inReady", 16'(in_ready), 16'h0);
    check("rst_outValid", 16'(out_valid), 16'h0);
    check("rst_outputs", 16'({s, s_hi}), 16'h0);
    check("rst_flags", 16'({flag_z, flag_n, flag_c, flag_v, err}), 16'h0);
    rst = 1'b0;
    tick();
    check("rst_release_inReady", 16'(in_ready), 16'h1);

    applyStimulus("add_ff_01", 8'hFF, 8'h01, 4'b0011);
    checkOutput("add_ff_01", 1, 8'h00, 8'h00, 5'b10100);
    applyStimulus("sub_80_01", 8'h80, 8'h01, 4'b0100);
    checkOutput("sub_80_01", 1, 8'h7F, 8'h00, 5'b00110);
    applyStimulus("sub_01_02", 8'h01, 8'h02, 4'b0100);
    checkOutput("sub_01_02", 1, 8'hFF, 8'h00, 5'b01000);
    applyStimulus("mul_ff_ff", 8'hFF, 8'hFF, 4'b1011);
    checkOutput("mul_ff_ff", 9, 8'h01, 8'hFE, 5'b00100);
    applyStimulus("mul_0f_11", 8'h0F, 8'h11, 4'b1011);
    checkOutput("mul_0f_11", 9, 8'hFF, 8'h00, 5'b01000);
    applyStimulus("shr_81_3", 8'h81, 8'h03, 4'b1001);
    checkOutput("shr_81_3", 4, 8'h10, 8'h00, 5'b00000);
    applyStimulus("shl_81_1", 8'h81, 8'h01, 4'b1000);
    checkOutput("shl_81_1", 2, 8'h02, 8'h00, 5'b00100);
    applyStimulus("shl_5a_0", 8'h5A, 8'h00, 4'b1000);
    checkOutput("shl_5a_0", 1, 8'h5A, 8'h00, 5'b00000);
    applyStimulus("xor_a5_0f", 8'hA5, 8'h0F, 4'b0111);
    checkOutput("xor_a5_0f", 1, 8'hAA, 8'h00, 5'b01000);
    applyStimulus("not_0f", 8'h0F, 8'h33, 4'b0001);
    checkOutput("not_0f", 1, 8'hF0, 8'h00, 5'b01000);
    applyStimulus("and_f0_3c", 8'hF0, 8'h3C, 4'b0101);
    checkOutput("and_f0_3c", 1, 8'h30, 8'h00, 5'b00000);
    applyStimulus("or_00_00", 8'h00, 8'h00, 4'b0110);
    checkOutput("or_00_00", 1, 8'h00, 8'h00, 5'b10000);
    applyStimulus("clear", 8'h77, 8'h66, 4'b1010);
    checkOutput("clear", 1, 8'h00, 8'h00, 5'b10000);
    applyStimulus("illegal_0010", 8'h12, 8'h34, 4'b0010);
    checkOutput("illegal_0010", 1, 8'h00, 8'h00, 5'b00001);

    out_ready = 1'b0;
    applyStimulus("bp_add", 8'h05, 8'h03, 4'b0011);
    a = 8'h10; b = 8'h20; aluMode = 4'b0011; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 16'(out_valid), 16'h1);
      check("bp_hold_s", 16'(s), 16'h08);
      check("bp_hold_inReady", 16'(in_ready), 16'h0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_outValid", 16'(out_valid), 16'h0);
    check("bp_release_inReady", 16'(in_ready), 16'h1);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", 16'(out_valid), 16'h1);
    check("bp_second_s", 16'(s), 16'h30);
    tick();

    applyStimulus("mul_abort", 8'hFF, 8'hFF, 4'b1011);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_outValid", 16'(out_valid), 16'h0);
    check("abort_s", 16'({s, s_hi}), 16'h0);
    check("abort_inReady", 16'(in_ready), 16'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_noResult", 16'(seen), 16'h0);
    check("abort_idleReady", 16'(in_ready), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
